// File: rtl/i2c_master_pkg.sv
// Shared constants for the I2C master bit-timing logic.
package i2c_master_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned TIMEOUT_CYC = 4096;

  localparam logic [1:0] SEG_NE   = 2'd0;
  localparam logic [1:0] SEG_WBIT = 2'd1;
  localparam logic [1:0] SEG_PE   = 2'd2;
  localparam logic [1:0] SEG_RBIT = 2'd3;

endpackage

// File: rtl/i2c_stretch_detect.sv
// SCL synchronizer and clock-stretch flag for the I2C master timebase.
// Optional stretch timeout enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_stretch_detect import i2c_master_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = i2c_master_pkg::TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_waiting,
  input  logic i_pe,
  input  logic i_rbit,
  input  logic i_scl,
  output logic o_stretch,
  output logic o_stretch_timeout
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stretch;
  logic                   w_stretch_d;
  logic                   w_scl_sync;
  logic                   w_to_hit;

  // The synchronizer is flushed at pe: samples taken before the master released
  // SCL are stale, so a release is only trusted once a fresh high has propagated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else if (i_pe) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_scl};
    end
  end

  assign w_scl_sync = r_sync[SYNC_STAGES-1];

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam logic [15:0] ToLast = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_to_cnt;
  logic        r_timeout;

  assign w_to_hit = r_stretch && (r_to_cnt == ToLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt <= r_stretch ? r_to_cnt + 16'd1 : 16'd0;
      if (i_waiting) begin
        r_timeout <= 1'b0;
      end else if (w_to_hit && !i_rbit && !i_pe) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_stretch_timeout = r_timeout;
`else
  logic [31:0] w_timeout_unused;

  assign w_timeout_unused  = TIMEOUT_CYC;
  assign w_to_hit          = 1'b0;
  assign o_stretch_timeout = 1'b0;
`endif

  always_comb begin
    w_stretch_d = r_stretch;
    if (i_waiting || i_rbit) begin
      w_stretch_d = 1'b0;
    end else if (i_pe) begin
      w_stretch_d = 1'b1;
    end else if (w_to_hit) begin
      w_stretch_d = 1'b0;
    end else if (r_stretch && w_scl_sync) begin
      w_stretch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stretch <= 1'b0;
    end else begin
      r_stretch <= w_stretch_d;
    end
  end

  assign o_stretch = r_stretch;

endmodule

// File: rtl/i2c_master_timebase.sv
// Quarter-bit phase counter and segment strobes for the I2C master FSM.
// Stretch timeout is included when I2C_STRETCH_TIMEOUT_EN is defined.
module i2c_master_timebase import i2c_master_pkg::*; #(
  parameter int unsigned CNT_W       = i2c_master_pkg::CNT_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = i2c_master_pkg::TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waiting,
  input  logic             scl,
  output logic [CNT_W-1:0] count,
  output logic             stretch,
  output logic             ne,
  output logic             wbit,
  output logic             pe,
  output logic             rbit,
  output logic             stretch_timeout
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic [1:0]       w_seg;
  logic             w_seg_start;
  logic             w_stretch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (waiting) begin
      r_count <= '0;
    end else if (!w_stretch) begin
      r_count <= r_count + CntOne;
    end
  end

  assign w_seg       = r_count[CNT_W-1 -: 2];
  assign w_seg_start = (r_count[CNT_W-3:0] == '0);

  assign ne   = w_seg_start && (w_seg == SEG_NE);
  assign wbit = w_seg_start && (w_seg == SEG_WBIT);
  assign pe   = w_seg_start && (w_seg == SEG_PE);
  assign rbit = w_seg_start && (w_seg == SEG_RBIT);

  i2c_stretch_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_stretch (
    .clk               (clk),
    .reset             (reset),
    .i_waiting         (waiting),
    .i_pe              (pe),
    .i_rbit            (rbit),
    .i_scl             (scl),
    .o_stretch         (w_stretch),
    .o_stretch_timeout (stretch_timeout)
  );

  assign count   = r_count;
  assign stretch = w_stretch;

endmodule

// File: tb/tb_i2c_master_timebase.sv
// Randomized bench for i2c_master_timebase against a cycle-level reference model.
module tb_i2c_master_timebase;

  localparam int CW    = 10;
  localparam int SS    = 2;
  localparam int TB_TO = 100;
  localparam int MODN  = 1 << CW;
  localparam int P_NE  = 0;
  localparam int P_WB  = 1 << (CW - 2);
  localparam int P_PE  = 2 << (CW - 2);
  localparam int P_RB  = 3 << (CW - 2);
`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          waiting;
  logic          scl;
  logic [CW-1:0] count;
  logic          stretch;
  logic          ne;
  logic          wbit;
  logic          pe;
  logic          rbit;
  logic          stretch_timeout;

  int total = 0;
  int bad   = 0;

  i2c_master_timebase #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .waiting         (waiting),
    .scl             (scl),
    .count           (count),
    .stretch         (stretch),
    .ne              (ne),
    .wbit            (wbit),
    .pe              (pe),
    .rbit            (rbit),
    .stretch_timeout (stretch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase value, stretch flag, sticky timeout, and the SCL
  // history seen since the last release point.
  int m_cnt;
  bit m_st;
  bit m_to;
  int m_stlen;
  int m_since_pe;
  int m_hist[SS];

  task automatic m_reset();
    m_cnt      = 0;
    m_st       = 1'b0;
    m_to       = 1'b0;
    m_stlen    = 0;
    m_since_pe = 1000;
    for (int i = 0; i < SS; i++) m_hist[i] = 1;
  endtask

  task automatic m_step(input bit w, input bit s);
    bit at_pe, at_rb, seen_high, fire, n_st;
    int n_cnt;
    at_pe     = (m_cnt == P_PE);
    at_rb     = (m_cnt == P_RB);
    // A release only counts once SS fresh samples have arrived after pe.
    seen_high = (m_since_pe >= SS) && (m_hist[SS-1] == 1);
    fire      = TO_EN && m_st && (m_stlen == TB_TO);
    n_cnt     = w ? 0 : (m_st ? m_cnt : (m_cnt + 1) % MODN);
    if (w || at_rb)          n_st = 1'b0;
    else if (at_pe)          n_st = 1'b1;
    else if (fire)           n_st = 1'b0;
    else if (m_st && seen_high) n_st = 1'b0;
    else                     n_st = m_st;
    if (w) m_to = 1'b0;
    else if (fire && !at_rb && !at_pe) m_to = 1'b1;
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0]  = s ? 1 : 0;
    m_since_pe = at_pe ? 0 : ((m_since_pe < 1000) ? m_since_pe + 1 : 1000);
    m_stlen    = n_st ? m_stlen + 1 : 0;
    m_st       = n_st;
    m_cnt      = n_cnt;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else        m_step(waiting, scl);
    end
  end

  // Compare process: all outputs against the model every cycle out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("count", int'(count), m_cnt);
        chk("stretch", int'(stretch), int'(m_st));
        chk("ne", int'(ne), int'(m_cnt == P_NE));
        chk("wbit", int'(wbit), int'(m_cnt == P_WB));
        chk("pe", int'(pe), int'(m_cnt == P_PE));
        chk("rbit", int'(rbit), int'(m_cnt == P_RB));
        chk("stretch_timeout", int'(stretch_timeout), int'(m_to));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_pe(input string name);
    int n = 0;
    while (!pe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!pe) chk(name, 0, 1);
  endtask

  initial begin
    int n, s, hold;
    reset   = 1'b0;
    waiting = 1'b0;
    scl     = 1'b1;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_stretch", int'(stretch), 0);
    chk("reset_timeout", int'(stretch_timeout), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("first_ne", int'(ne), 1);

    // Free run with SCL released: minimum freeze and segment spacing.
    wait_pe("wait_pe_run");
    chk("pe_at_512", int'(count), 512);
    n = 0;
    s = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (stretch) s++;
      if (rbit) break;
    end
    chk("pe_to_rbit", n, 259);
    chk("min_freeze", s, 3);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (ne) break;
    end
    chk("rbit_to_ne_wrap", n, 256);

    // Slave holds SCL low after pe.
    wait_pe("wait_pe_hold");
    scl = 1'b0;
`ifndef I2C_STRETCH_TIMEOUT_EN
    repeat (500) @(negedge clk);
    chk("held_count", int'(count), 513);
    chk("held_stretch", int'(stretch), 1);
    chk("held_no_timeout", int'(stretch_timeout), 0);
    scl = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (rbit) break;
    end
    chk("release_to_rbit", n, 258);
`else
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!stretch) break;
      n++;
    end
    chk("timeout_len", n, TB_TO);
    chk("timeout_set", int'(stretch_timeout), 1);
    n = 0;
    while (!rbit && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_sticky", int'(stretch_timeout), 1);
    scl = 1'b1;
`endif

    // waiting pulse mid-count.
    n = 0;
    while (count != 10'd600 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_600", int'(count), 600);
    waiting = 1'b1;
    @(negedge clk);
    chk("wait_count", int'(count), 0);
    chk("wait_stretch", int'(stretch), 0);
    chk("wait_ne", int'(ne), 1);
    chk("wait_clears_timeout", int'(stretch_timeout), 0);
    waiting = 1'b0;
    @(negedge clk);
    chk("restart_count", int'(count), 1);

    // Randomized traffic; the compare process does the checking.
    hold = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        scl  = ($urandom_range(0, 4) != 0);
        hold = $urandom_range(1, 30);
      end else begin
        hold--;
      end
      waiting = ($urandom_range(0, 599) == 0);
    end
    waiting = 1'b0;
    scl     = 1'b1;

    // Asynchronous reset in the middle of a stretch.
    scl = 1'b0;
    wait_pe("wait_pe_reset");
    @(negedge clk);
    chk("pre_reset_count", int'(count), 513);
    chk("pre_reset_stretch", int'(stretch), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_stretch", int'(stretch), 0);
    @(negedge clk);
    reset = 1'b1;
    scl   = 1'b1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
